// File: rtl/fibo_seq_gen.sv
// fibo_seq_gen: emits a Fibonacci-style sequence from two seeds over a valid/ready port,
// with optional term count, hold, and a sticky wrap flag.
module fibo_seq_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_hold,
    input  logic [WIDTH-1:0] i_seed_a,
    input  logic [WIDTH-1:0] i_seed_b,
    input  logic [CNT_W-1:0] i_n_terms,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic [CNT_W-1:0] r_cnt, r_len;
    logic             r_ovf;
    logic [WIDTH:0]   w_sum;
    logic             w_xfer, w_last;
    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
    assign o_out_valid = (r_state == RUN) && !i_hold;
    assign w_xfer      = o_out_valid && i_out_ready && !i_start;
    assign w_last      = (r_len != '0) && (r_cnt == r_len - CNT_W'(1));
    assign o_out_data  = r_a;
    assign o_busy      = r_state == RUN;
    assign o_done      = r_state == DONE;
    assign o_ovf       = r_ovf;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (i_start) w_next = RUN;
        else if (w_xfer && w_last) w_next = DONE;
    end
    // The final term's transfer leaves a/b/cnt parked; only the wrap flag still updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (i_start) begin
            r_a   <= i_seed_a;
            r_b   <= i_seed_b;
            r_cnt <= '0;
            r_len <= i_n_terms;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_ovf <= r_ovf | w_sum[WIDTH];
            if (!w_last) begin
                r_a   <= r_b;
                r_b   <= w_sum[WIDTH-1:0];
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fibo_seq_gen.sv
// tb_fibo_seq_gen: directed scenario checks of fibo_seq_gen with hand-computed expectations.
module tb_fibo_seq_gen;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0, out_ready = 1'b0;
    logic [7:0] seed_a = '0, seed_b = '0, n_terms = '0;
    logic [7:0] out_data;
    logic       out_valid, busy, done, ovf;
    int errors = 0, checks = 0;
    int fib8  [8]  = '{0, 1, 1, 2, 3, 5, 8, 13};
    int fib16 [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    fibo_seq_gen #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_hold(hold), .i_seed_a(seed_a),
        .i_seed_b(seed_b), .i_n_terms(n_terms), .o_out_data(out_data), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_busy(busy), .o_done(done), .o_ovf(ovf)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic begin_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
        start = 1'b1; seed_a = a; seed_b = b; n_terms = n; out_ready = 1'b1; hold = 1'b0;
        tick;
        start = 1'b0;
    endtask
    task automatic test_reset;
        #2;
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", out_data); end
        checks++; if ({out_valid, busy, done, ovf} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, busy, done, ovf}); end
        tick;
        rst = 1'b0; out_ready = 1'b1;
        tick;
        checks++; if ({out_valid, busy, done} !== 3'b0) begin errors++; $display("FAIL idle_flags got=%b exp=000", {out_valid, busy, done}); end
    endtask
    task automatic test_basic;
        begin_seq(8'd0, 8'd1, 8'd8);
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got=%b%b exp=11", i, out_valid, busy); end
            checks++; if (out_data !== 8'(fib8[i])) begin errors++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, out_data, fib8[i]); end
            tick;
        end
        checks++; if ({done, out_valid, busy, ovf} !== 4'b1000) begin errors++; $display("FAIL basic_done got=%b exp=1000", {done, out_valid, busy, ovf}); end
    endtask
    task automatic test_ovf;
        begin_seq(8'd0, 8'd1, 8'd16);
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_data !== 8'(fib16[i])) begin errors++; $display("FAIL ovf_data[%0d] got=%0d exp=%0d", i, out_data, fib16[i]); end
            checks++; if (ovf !== (i >= 13)) begin errors++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, ovf, i >= 13); end
            tick;
        end
        checks++; if ({done, out_valid, ovf} !== 3'b101) begin errors++; $display("FAIL ovf_done got=%b exp=101", {done, out_valid, ovf}); end
    endtask
    task automatic test_stall;
        logic [7:0] rdy   = 8'b1110_1001;
        logic [7:0] hld   = 8'b0001_0000;
        int         dat [8] = '{3, 4, 4, 4, 7, 7, 11, 18};
        begin_seq(8'd3, 8'd4, 8'd0);
        for (int i = 0; i < 8; i++) begin
            out_ready = rdy[i]; hold = hld[i];
            #1;
            checks++; if (out_data !== 8'(dat[i])) begin errors++; $display("FAIL stall_data[%0d] got=%0d exp=%0d", i, out_data, dat[i]); end
            checks++; if (out_valid !== !hld[i] || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stall_flags[%0d] got=%b%b%b exp=%b10", i, out_valid, busy, done, !hld[i]); end
            tick;
        end
        hold = 1'b0; out_ready = 1'b1;
    endtask
    task automatic test_reset_mid;
        begin_seq(8'd200, 8'd100, 8'd0);
        checks++; if (out_data !== 8'd200) begin errors++; $display("FAIL rm_first got=%0d exp=200", out_data); end
        repeat (5) tick;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL rm_ovf_set got=%b exp=1", ovf); end
        rst = 1'b1;
        #1;
        checks++; if (out_data !== 8'd0 || {out_valid, busy, done, ovf} !== 4'b0) begin errors++; $display("FAIL rm_async got=%0d/%b exp=0/0000", out_data, {out_valid, busy, done, ovf}); end
        start = 1'b1; seed_a = 8'd9; seed_b = 8'd9; n_terms = 8'd0;
        tick;
        start = 1'b0; rst = 1'b0;
        tick;
        checks++; if ({out_valid, busy, done} !== 3'b0 || out_data !== 8'd0) begin errors++; $display("FAIL rm_start_ignored got=%b/%0d exp=000/0", {out_valid, busy, done}, out_data); end
        begin_seq(8'd5, 8'd5, 8'd3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i == 2 ? 10 : 5)) begin errors++; $display("FAIL rm_seq[%0d] got=%0d exp=%0d", i, out_data, i == 2 ? 10 : 5); end
            tick;
        end
        checks++; if ({done, out_valid} !== 2'b10) begin errors++; $display("FAIL rm_done got=%b exp=10", {done, out_valid}); end
    endtask
    task automatic test_back_to_back;
        begin_seq(8'd200, 8'd100, 8'd0);
        repeat (2) tick;
        checks++; if (out_data !== 8'd44 || ovf !== 1'b1) begin errors++; $display("FAIL b2b_pre got=%0d/%b exp=44/1", out_data, ovf); end
        begin_seq(8'd2, 8'd2, 8'd2);
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_data !== 8'd2 || out_valid !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL b2b_seq[%0d] got=%0d/%b/%b exp=2/1/0", i, out_data, out_valid, ovf); end
            tick;
        end
        checks++; if ({done, out_valid, ovf} !== 3'b100) begin errors++; $display("FAIL b2b_done got=%b exp=100", {done, out_valid, ovf}); end
        repeat (2) tick;
        checks++; if ({done, out_valid, busy} !== 3'b100) begin errors++; $display("FAIL b2b_stay got=%b exp=100", {done, out_valid, busy}); end
    endtask
    initial begin
        test_reset;
        test_basic;
        test_ovf;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
